// File: rtl/btn_conditioner.sv
// Four-button input conditioner: two-flop synchroniser, per-bit debouncer and a
// lockout arbiter that emits one single-cycle, one-hot press per physical touch.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_press,
    output logic [3:0] btn_held,
    output logic       locked
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_ARMED  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    logic [3:0]    s1_q, s2_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    held_q, held_d;
    logic [3:0]    press_q, press_d;
    logic [3:0]    rise;
    state_t        state_q, state_d;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would let s2 see this cycle's s1 and collapse the synchroniser.
    // NOTE: the debounce counters are ordinary flops, not a RAM, so they are reset
    // with everything else; a stale count would otherwise shorten the first debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            held_q  <= '0;
            press_q <= '0;
            state_q <= ST_ARMED;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            s1_q    <= btn_raw;
            s2_q    <= s1_q;
            held_q  <= held_d;
            press_q <= press_d;
            state_q <= state_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        held_d = held_q;
        rise   = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                held_d[i] = s2_q[i];
                cnt_d[i]  = '0;
                rise[i]   = s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Unlock only once the held vector about to be registered is empty, so a
    // release on one bit and a rise on another in the same cycle stays locked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARMED:  if (rise != 4'b0000)   state_d = ST_LOCKED;
            ST_LOCKED: if (held_d == 4'b0000) state_d = ST_ARMED;
            default:   state_d = ST_ARMED;
        endcase
    end

    always_comb begin
        press_d = 4'b0000;
        locked  = (state_q == ST_LOCKED);
        if (state_q == ST_ARMED) press_d = rise & (~rise + 4'd1);
    end

    assign btn_press = press_q;
    assign btn_held  = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4: clean press, bounce,
// chord, overlap, reset mid-press and a short glitch, with hand-derived edge timing.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_press;
    logic [3:0] btn_held;
    logic       locked;

    int checks     = 0;
    int failures   = 0;
    int press_cnt  = 0;
    int bad_shape  = 0;
    logic [3:0] last_press = 4'b0000;
    logic [3:0] prev_press = 4'b0000;

    btn_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_press (btn_press),
        .btn_held  (btn_held),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later; tracks pulse count and shape.
    task automatic tick();
        @(posedge clk);
        #1;
        if (btn_press != 4'b0000) begin
            press_cnt++;
            last_press = btn_press;
            if ((btn_press & (btn_press - 4'd1)) != 4'b0000) bad_shape++;
            if (prev_press != 4'b0000) bad_shape++;
        end
        prev_press = btn_press;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b0000;
        run(2);
        check("reset_press",  {28'd0, btn_press}, 32'h0);
        check("reset_held",   {28'd0, btn_held},  32'h0);
        check("reset_locked", {31'd0, locked},    32'h0);
        rst = 1'b0;
        run(3);

        // Clean press on bit2: raw set before edge k, held 20 edges
        press_cnt = 0;
        btn_raw = 4'b0100;
        run(5);
        check("clean_press_early", {28'd0, btn_press}, 32'h0);
        check("clean_held_early",  {28'd0, btn_held},  32'h0);
        tick();
        check("clean_press",  {28'd0, btn_press}, 32'h4);
        check("clean_held",   {28'd0, btn_held},  32'h4);
        check("clean_locked", {31'd0, locked},    32'h1);
        tick();
        check("clean_press_1cyc", {28'd0, btn_press}, 32'h0);
        run(13);
        btn_raw = 4'b0000;
        run(5);
        check("clean_held_before_fall",   {28'd0, btn_held}, 32'h4);
        check("clean_locked_before_fall", {31'd0, locked},   32'h1);
        tick();
        check("clean_held_fall",   {28'd0, btn_held}, 32'h0);
        check("clean_locked_fall", {31'd0, locked},   32'h0);
        check("clean_pulse_count", press_cnt, 32'd1);
        run(2);

        // Bounce on bit0: 2-cycle pulses never accepted, final rise accepted
        press_cnt = 0;
        btn_raw = 4'b0001; run(2);
        btn_raw = 4'b0000; run(2);
        btn_raw = 4'b0001; run(2);
        btn_raw = 4'b0000; run(2);
        check("bounce_no_pulse", press_cnt, 32'd0);
        check("bounce_no_held",  {28'd0, btn_held}, 32'h0);
        btn_raw = 4'b0001;
        run(5);
        check("bounce_press_early", {28'd0, btn_press}, 32'h0);
        tick();
        check("bounce_press", {28'd0, btn_press}, 32'h1);
        btn_raw = 4'b0000;
        run(8);
        check("bounce_pulse_count", press_cnt, 32'd1);
        check("bounce_unlocked", {31'd0, locked}, 32'h0);

        // Chord bits 1 and 3: lowest index wins, no later bit3 pulse
        press_cnt = 0;
        btn_raw = 4'b1010;
        run(6);
        check("chord_press", {28'd0, btn_press}, 32'h2);
        check("chord_held",  {28'd0, btn_held},  32'ha);
        run(10);
        btn_raw = 4'b1000;
        run(6);
        check("chord_partial_held",   {28'd0, btn_held}, 32'h8);
        check("chord_partial_locked", {31'd0, locked},   32'h1);
        btn_raw = 4'b0000;
        run(6);
        check("chord_unlocked",    {31'd0, locked}, 32'h0);
        check("chord_pulse_count", press_cnt, 32'd1);
        check("chord_last_press",  {28'd0, last_press}, 32'h2);

        // Overlap: bit2 pressed while bit0 held is ignored, then works alone
        press_cnt = 0;
        btn_raw = 4'b0001;
        run(6);
        check("overlap_press0", {28'd0, btn_press}, 32'h1);
        run(2);
        btn_raw = 4'b0101;
        run(8);
        check("overlap_held",        {28'd0, btn_held}, 32'h5);
        check("overlap_pulse_count", press_cnt, 32'd1);
        btn_raw = 4'b0000;
        run(6);
        check("overlap_unlocked", {31'd0, locked}, 32'h0);
        btn_raw = 4'b0100;
        run(6);
        check("overlap_press2", {28'd0, btn_press}, 32'h4);
        btn_raw = 4'b0000;
        run(7);
        check("overlap_total_pulses", press_cnt, 32'd2);

        // Reset mid-press with bit3 held and LOCKED
        press_cnt = 0;
        btn_raw = 4'b1000;
        run(6);
        check("rstmid_press", {28'd0, btn_press}, 32'h8);
        run(3);
        check("rstmid_locked_before", {31'd0, locked}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_async_held",   {28'd0, btn_held}, 32'h0);
        check("rstmid_async_locked", {31'd0, locked},   32'h0);
        run(3);
        rst = 1'b0;
        press_cnt = 0;
        run(5);
        check("rstmid_press_early", {28'd0, btn_press}, 32'h0);
        tick();
        check("rstmid_press_again", {28'd0, btn_press}, 32'h8);
        check("rstmid_locked_again", {31'd0, locked},   32'h1);
        btn_raw = 4'b0000;
        run(8);
        check("rstmid_pulse_count", press_cnt, 32'd1);

        // Short 3-cycle glitch on bit1: count peaks at the bound, then clears
        press_cnt = 0;
        btn_raw = 4'b0010;
        run(3);
        btn_raw = 4'b0000;
        run(2);
        check("glitch_cnt_peak", {30'd0, dut.cnt_q[1]}, 32'd3);
        check("glitch_held_peak", {28'd0, btn_held}, 32'h0);
        run(4);
        check("glitch_cnt_clear", {30'd0, dut.cnt_q[1]}, 32'd0);
        check("glitch_held",      {28'd0, btn_held},     32'h0);
        check("glitch_no_pulse",  press_cnt, 32'd0);

        check("pulse_shape", bad_shape, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Input conditioner between the four raw player push-buttons and the game FSM. It synchronises and debounces each button and enforces one-press-per-touch lockout. It drives the FSM's `btn` input with a single-cycle, strictly one-hot press pulse, so the FSM never sees bounce, chords or a held button as repeated input.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive synchronised cycles a new level must persist to be accepted. 10 ms at 50 MHz. Legal range 2 to 2^20.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high; clock `clk`.
- `btn_raw`  in  4  raw buttons, active-high, asynchronous to `clk`. Bit i is colour i.
- `btn_press`  out  4  one-hot press pulse, high for exactly 1 cycle per accepted press. Connects to FSM `btn`.
- `btn_held`  out  4  debounced level of each button.
- `locked`  out  1  high from an accepted press until all buttons are debounced-released.

## Operation
- **Synchroniser.** Per bit, two flops: `s1 <= btn_raw`, `s2 <= s1`. No logic between them.
- **Debouncer.** Per bit i, counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`.
  - On each edge, if `s2[i] == btn_held[i]`: `cnt[i] <= 0`.
  - Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `btn_held[i] <= s2[i]` and `cnt[i] <= 0`.
  - Otherwise: `cnt[i] <= cnt[i]+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and is never seen.
- **Rise vector.** `rise[i]` is high on the edge where `btn_held[i]` goes 0→1, i.e. the flip condition with `s2[i]=1`. It is computed combinationally so the press shares that edge.
- **Arbiter FSM**, 2 states:
  - **ARMED** (`locked=0`): if `rise != 0`, register `btn_press` = lowest-index set bit of `rise`, then go to LOCKED. Otherwise `btn_press <= 0`.
  - **LOCKED** (`locked=1`): `btn_press <= 0` every cycle. Further rises are ignored, including a second button pressed while the first is held. Go to ARMED on the edge where the next-state `btn_held` is all zero.
- **Simultaneous rises.** Two or more rises on the same edge in ARMED produce a pulse for the lowest index only, e.g. rise=4'b0110 gives btn_press=4'b0010.
- **Release and re-rise on the same edge.** Not possible per bit. Across bits, the release of button A and the rise of button B on one edge: held goes nonzero, so the block stays LOCKED and B produces no pulse.
- **Pulse shape.** `btn_press` is never multi-hot and never high two consecutive cycles.

## Timing
- **Reset values.** `btn_press=0`, `btn_held=0`, `locked=0`, all `s1`/`s2`/`cnt` = 0, state ARMED. Reset acts immediately (asynchronous) and releases synchronously to `clk`.
- **Latency.** Raw rising before edge k, stable thereafter:
  - `s2` high after edge k+1.
  - `btn_held` and `btn_press` high after edge k+1+`DEBOUNCE_CYCLES`.
  - `btn_press` low again after the following edge.
- **Release latency.** Same, `DEBOUNCE_CYCLES+1` edges from raw fall to `btn_held` fall. `locked` falls on that same edge.
- **Reset mid-operation.** All state is cleared, including LOCKED. A button physically held through reset is re-debounced from `held=0` and yields one fresh press `DEBOUNCE_CYCLES+1` edges after the first edge following reset deassertion. The POWER_ON exit relies on this.
- **Counter bound.** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
1. **Clean press.** btn_raw 0→4'b0100 before edge 10, held 20 cycles, then released. Expect:
   - btn_press=4'b0100 only after edge 15, 1 cycle.
   - btn_held[2] high after edges 15–34 (falls after edge 35).
   - locked high after edges 15–34.
2. **Bounce.** bit0 toggles 1,0,1,0 every 2 cycles, then stays high. Expect no pulse during bounce, and exactly one 4'b0001 pulse 5 edges after the final rise.
3. **Chord.** Bits 1 and 3 rise before the same edge. Expect a single 4'b0010 pulse, btn_held=4'b1010, and no 4'b1000 pulse while either is held.
4. **Overlap.** Hold bit0, then press bit2 before bit0 is released. Expect only the bit0 pulse. Release both, then press bit2 alone: expect a 4'b0100 pulse.
5. **Reset mid-press.** Assert rst for 3 cycles while bit3 is held and the block is LOCKED. Expect all outputs 0 immediately, then a 4'b1000 pulse 5 edges after reset release.
6. **Short glitch.** A 3-cycle raw pulse on bit1. Expect btn_held and btn_press to stay 0 and cnt[1] to return to 0.
